booth_arb_seq: RTL and testbench
================================

BOOTH_ARB_SEQ -- requirements
Module: booth_arb_seq

Interface
REQ-001 The module SHALL have parameter BW, default 4, giving the operand width in bits (minimum 2).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have ports in0_valid input 1, in0_ready output 1, in0_x input BW signed, in0_y input BW signed: requester 0 multiply request.
REQ-005 The module SHALL have ports in1_valid input 1, in1_ready output 1, in1_x input BW signed, in1_y input BW signed: requester 1 multiply request.
REQ-006 The module SHALL have ports out_valid output 1, out_ready input 1, out_z output 2*BW signed product, out_id output 1 (requester index).
REQ-007 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-008 The module SHALL share one iterative radix-2 Booth datapath between the two requesters and perform one Booth step per clock.
REQ-009 The module SHALL implement FSM states IDLE, ITER and DONE: IDLE->ITER on accept, ITER->DONE after BW steps, DONE->IDLE when out_valid && out_ready.
REQ-010 In IDLE, the module SHALL assert inN_ready only for the granted requester; all inN_ready SHALL be 0 in ITER and DONE.
REQ-011 A request SHALL be accepted on a rising edge where inN_valid && inN_ready; operands and requester index SHALL be latched on that edge.
REQ-012 With only one valid requester in IDLE, it SHALL be granted in the same cycle, with no idle bubble.
REQ-013 With both valid in IDLE, grant SHALL go to the requester not served last (round-robin); after reset, requester 0 SHALL have priority.
REQ-014 Step i (i=0..BW-1) SHALL examine {x[i], x[i-1]} with x[-1]=0: 10 subtract y, 01 add y, 00/11 no add, followed by an arithmetic right shift of the accumulator.
REQ-015 The upper accumulator SHALL be BW+1 bits wide so that subtracting y = -2^(BW-1) never overflows.
REQ-016 out_z SHALL be the exact signed product for all operand pairs, including x = y = -2^(BW-1) (BW=4: -8 * -8 = 64).
REQ-017 out_valid SHALL rise exactly BW+1 rising edges after the accept edge and remain high, with out_z and out_id stable, until out_ready is sampled high.
REQ-018 out_ready asserted while out_valid is 0 SHALL have no effect.
REQ-019 inN_x and inN_y changing after the accept edge SHALL NOT affect the result in flight.
REQ-020 A new request SHALL NOT be accepted in the same cycle as the DONE->IDLE handshake; the earliest accept is the following cycle.

Reset
REQ-021 On rst_n low, the module SHALL immediately set the state to IDLE, out_valid=0, out_z=0, out_id=0, busy=0, the step counter to 0 and round-robin priority to requester 0.
REQ-022 Reset asserted mid-operation SHALL discard the operation in flight; no result for it SHALL ever be presented.
REQ-023 After rst_n rises, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-024 With macro BOOTH_ARB_STATS_EN defined, the module SHALL add outputs op_cnt0 and op_cnt1, 16 bits each, counting completed output handshakes per requester; the counters SHALL wrap from 0xFFFF to 0 and reset to 0.
REQ-025 Without BOOTH_ARB_STATS_EN, op_cnt0, op_cnt1 and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 BW=4, in0 x=3 y=-2, out_ready=1 -> out_valid rises 5 edges after accept, out_z=-6, out_id=0.
REQ-027 BW=4, in1 x=-8 y=-8 -> out_z=64, out_id=1; x=-8 y=7 -> out_z=-56.
REQ-028 Both requesters valid continuously after reset -> grants alternate 0,1,0,1, and each inN_ready pulses only in IDLE.
REQ-029 out_ready held low for 10 cycles in DONE -> out_valid, out_z and out_id stay stable and no inN_ready is asserted; out_ready=1 -> IDLE on the next edge.
REQ-030 rst_n pulsed low during the 2nd ITER cycle -> all outputs are 0 immediately, and no stale result appears after release.
REQ-031 With BOOTH_ARB_STATS_EN, 3 ops on in0 and 2 ops on in1 -> op_cnt0=3, op_cnt1=2; preloading a count of 0xFFFF and completing one more op -> the count wraps to 0.

Source files
------------

// File: rtl/booth_arb_seq.sv
// booth_arb_seq: two-requester round-robin front end sharing one
// iterative radix-2 Booth multiplier (one step per clock).
// Ports: clk, rst_n (async, active-low); in0_*/in1_* valid/ready
// requests with signed BW-bit x,y; out_valid/out_ready result with
// signed 2*BW-bit out_z and requester out_id; busy (not IDLE).
// Optional: define BOOTH_ARB_STATS_EN to add 16-bit op_cnt0/op_cnt1
// counters of completed output handshakes per requester.
module booth_arb_seq #(
  parameter int BW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in0_valid,
  output logic                 in0_ready,
  input  logic signed [BW-1:0] in0_x,
  input  logic signed [BW-1:0] in0_y,
  input  logic                 in1_valid,
  output logic                 in1_ready,
  input  logic signed [BW-1:0] in1_x,
  input  logic signed [BW-1:0] in1_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [2*BW-1:0] out_z,
  output logic                 out_id,
  output logic                 busy
`ifdef BOOTH_ARB_STATS_EN
  ,
  output logic [15:0]          op_cnt0,
  output logic [15:0]          op_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  // acc = {a[BW:0], q[BW-1:0], q_m1}
  localparam int AW = 2*BW + 2;
  localparam int CW = $clog2(BW + 1);

  state_t                 state_q, state_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic signed [BW-1:0]   y_q, y_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic                   out_valid_q, out_valid_d;
  logic signed [2*BW-1:0] out_z_q, out_z_d;
  logic                   out_id_q, out_id_d;

  logic                   grant0, grant1;
  logic signed [BW:0]     a_cur, y_ext, a_sum;
  logic                   hs;

  // last_q=1 means requester 1 was served last, so 0 wins a tie
  assign grant0 = in0_valid && (!in1_valid || last_q);
  assign grant1 = in1_valid && (!in0_valid || !last_q);

  assign in0_ready = (state_q == IDLE) && grant0;
  assign in1_ready = (state_q == IDLE) && grant1;

  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);
  assign hs        = (state_q == DONE) && out_ready;

  // one Booth step: add/sub on the BW+1 bit upper half
  always_comb begin
    a_cur = acc_q[AW-1 -: BW+1];
    y_ext = {y_q[BW-1], y_q};
    unique case (acc_q[1:0])
      2'b10:   a_sum = a_cur - y_ext;
      2'b01:   a_sum = a_cur + y_ext;
      default: a_sum = a_cur;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    out_id_d    = out_id_q;
    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d  = ITER;
          acc_d    = {{(BW+1){1'b0}},
                      (grant1 ? in1_x : in0_x), 1'b0};
          y_d      = grant1 ? in1_y : in0_y;
          cnt_d    = '0;
          last_d   = grant1;
          out_id_d = grant1;
        end
      end
      ITER: begin
        if (cnt_q == CW'(BW)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_z_d     = acc_q[2*BW:1];
        end else begin
          // arithmetic right shift of {a,q,q_m1}
          acc_d = {a_sum[BW], a_sum, acc_q[BW:2], acc_q[1]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_id_q    <= out_id_d;
    end
  end

`ifdef BOOTH_ARB_STATS_EN
  logic [15:0] op_cnt0_q, op_cnt0_d;
  logic [15:0] op_cnt1_q, op_cnt1_d;

  always_comb begin
    op_cnt0_d = op_cnt0_q;
    op_cnt1_d = op_cnt1_q;
    if (hs && !out_id_q) op_cnt0_d = op_cnt0_q + 16'd1;
    if (hs && out_id_q)  op_cnt1_d = op_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt0_q <= '0;
      op_cnt1_q <= '0;
    end else begin
      op_cnt0_q <= op_cnt0_d;
      op_cnt1_q <= op_cnt1_d;
    end
  end

  assign op_cnt0 = op_cnt0_q;
  assign op_cnt1 = op_cnt1_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_booth_arb_seq.sv
// tb_booth_arb_seq: directed checks of booth_arb_seq (BW=4):
// products, latency, round-robin, stall, mid-op reset.
module tb_booth_arb_seq;

  localparam int BW = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 in0_valid, in1_valid;
  logic                 in0_ready, in1_ready;
  logic signed [BW-1:0] in0_x, in0_y, in1_x, in1_y;
  logic                 out_valid, out_ready;
  logic signed [2*BW-1:0] out_z;
  logic                 out_id;
  logic                 busy;
`ifdef BOOTH_ARB_STATS_EN
  logic [15:0]          op_cnt0, op_cnt1;
`endif

  int tests = 0;
  int fails = 0;

  booth_arb_seq #(.BW(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_x     (in0_x),
    .in0_y     (in0_y),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_x     (in1_x),
    .in1_y     (in1_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_id    (out_id),
    .busy      (busy)
`ifdef BOOTH_ARB_STATS_EN
    ,
    .op_cnt0   (op_cnt0),
    .op_cnt1   (op_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got,
                     input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one full transaction on a single requester with out_ready=1
  task automatic op(input bit id, input int x, input int y,
                    input int zexp, input string tag);
    int lat;
    @(negedge clk);
    if (id) begin
      in1_x = x[3:0]; in1_y = y[3:0]; in1_valid = 1'b1;
    end else begin
      in0_x = x[3:0]; in0_y = y[3:0]; in0_valid = 1'b1;
    end
    #1;
    chk({tag, "_rdy"}, id ? in1_ready : in0_ready, 1);
    chk({tag, "_rdy_oth"}, id ? in0_ready : in1_ready, 0);
    @(posedge clk);
    #1;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_x = 4'sd5; in0_y = -4'sd3;
    in1_x = -4'sd5; in1_y = 4'sd6;
    chk({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, BW + 1);
    chk({tag, "_z"}, out_z, zexp);
    chk({tag, "_id"}, out_id, int'(id));
    @(posedge clk);
    #1;
    chk({tag, "_vld_off"}, out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int exp_id, lat, bad;
    logic signed [2*BW-1:0] z_hold;
    logic id_hold;

    rst_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_x = '0; in0_y = '0; in1_x = '0; in1_y = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_z", out_z, 0);
    chk("rst_id", out_id, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    op(1'b0, 3, -2, -6, "m3x-2");
    op(1'b1, -8, -8, 64, "m-8x-8");
    op(1'b1, -8, 7, -56, "m-8x7");
    op(1'b0, 7, 7, 49, "m7x7");
    op(1'b0, -1, -1, 1, "m-1x-1");
    op(1'b0, 0, -8, 0, "m0x-8");

    // round-robin from reset with both requesters always valid
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in0_x = 4'sd2;  in0_y = 4'sd3;
    in1_x = -4'sd3; in1_y = 4'sd2;
    in0_valid = 1'b1; in1_valid = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_id = g % 2;
      chk("rr_rdy0", in0_ready, int'(exp_id == 0));
      chk("rr_rdy1", in1_ready, int'(exp_id == 1));
      @(posedge clk);
      #1;
      bad = 0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        if (in0_ready || in1_ready) bad++;
        @(posedge clk);
        #1;
        lat++;
      end
      if (in0_ready || in1_ready) bad++;
      chk("rr_lat", lat, BW + 1);
      chk("rr_no_rdy", bad, 0);
      chk("rr_id", out_id, exp_id);
      chk("rr_z", out_z, exp_id == 0 ? 6 : -6);
      @(posedge clk);
      #1;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;

    // output stall for 10 cycles
    @(negedge clk);
    out_ready = 1'b0;
    in0_x = 4'sd5; in0_y = 4'sd3; in0_valid = 1'b1;
    @(posedge clk);
    #1;
    in0_valid = 1'b0;
    in1_x = 4'sd1; in1_y = 4'sd1; in1_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("st_lat", lat, BW + 1);
    chk("st_z", out_z, 15);
    z_hold = out_z;
    id_hold = out_id;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (!out_valid || out_z !== z_hold || out_id !== id_hold)
        bad++;
      if (in0_ready || in1_ready) bad++;
    end
    chk("st_stable", bad, 0);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("st_no_same_acc", in1_ready, 0);
    @(posedge clk);
    #1;
    chk("st_vld_off", out_valid, 0);
    chk("st_next_rdy", in1_ready, 1);
    in1_valid = 1'b0;

    // reset during the second ITER cycle
    @(negedge clk);
    in0_x = 4'sd7; in0_y = 4'sd7; in0_valid = 1'b1;
    @(posedge clk);
    #1;
    in0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_z", out_z, 0);
    chk("mr_id", out_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) bad++;
    end
    chk("mr_no_stale", bad, 0);

    op(1'b1, 4, -4, -16, "m4x-4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
